// File: rtl/pconv_accum_unit_if.sv
// pconv_accum_unit_if
//   Bundles the beat-input handshake, the result-output handshake and the
//   busy status of the pointwise-convolution accumulate unit.
//   master : producer/consumer side (drives beats, out_rdy)
//   slave  : the accumulate unit itself
// Signals
//   in_vld / in_rdy / in_last : beat handshake, in_last marks a pixel's final beat
//   input_din / weight_din    : LANES packed signed N-bit activations / weights
//   bias_din                  : signed ACC_W bias, taken from a pixel's first beat
//   shift_din / relu_en       : requant shift and ReLU enable, taken from the last beat
//   out_vld / out_rdy         : result handshake
//   out_dout / out_sat        : signed N-bit result and saturation flag
//   busy                      : pixel in progress or any stage occupied
interface pconv_accum_unit_if #(
    parameter int N     = 16,
    parameter int LANES = 8,
    parameter int ACC_W = 32
);
    logic               in_vld;
    logic               in_rdy;
    logic               in_last;
    logic [LANES*N-1:0] input_din;
    logic [LANES*N-1:0] weight_din;
    logic [ACC_W-1:0]   bias_din;
    logic [4:0]         shift_din;
    logic               relu_en;
    logic               out_vld;
    logic               out_rdy;
    logic [N-1:0]       out_dout;
    logic               out_sat;
    logic               busy;

    modport master (
        output in_vld, in_last, input_din, weight_din, bias_din, shift_din, relu_en, out_rdy,
        input  in_rdy, out_vld, out_dout, out_sat, busy
    );

    modport slave (
        input  in_vld, in_last, input_din, weight_din, bias_din, shift_din, relu_en, out_rdy,
        output in_rdy, out_vld, out_dout, out_sat, busy
    );
endinterface

// File: rtl/pconv_accum_unit.sv
// pconv_accum_unit
//   Pointwise (1x1) convolution output unit. Each beat carries LANES
//   activation/weight pairs; a pixel is the sum of one or more beats plus a
//   bias, then requantised by an arithmetic right shift, optionally ReLU'd and
//   saturated to [-(OUT_MAX+1), OUT_MAX].
//   Four-stage pipeline: S1 products, S2 lane sum, S3 accumulator, S4 output.
//   The whole pipeline advances only when the output register can move.
// Ports
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   accIf  : pconv_accum_unit_if.slave (beat input, result output, busy)
// Build option
//   PCONV_ROUND_EN : when defined, round half up before the shift
//                    (adds 1<<(shift-1) when shift>0); otherwise floor.
module pconv_accum_unit #(
    parameter int N       = 16,
    parameter int LANES   = 8,
    parameter int ACC_W   = 32,
    parameter int OUT_MAX = 127
) (
    input logic              clk,
    input logic              rst_n,
    pconv_accum_unit_if.slave accIf
);
    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] NEG_LIM = -ACC_W'(OUT_MAX + 1);

    // Full-precision signed product of one lane, sign-extended to ACC_W.
    function automatic logic signed [ACC_W-1:0] laneProduct(input logic signed [N-1:0] a,
                                                            input logic signed [N-1:0] b);
        logic signed [2*N-1:0] p;
        p = a * b;
        return ACC_W'(p);
    endfunction

    logic                    advance;

    logic                    s1Valid_q, s1Last_q, s1Relu_q;
    logic signed [ACC_W-1:0] s1Prod_q [LANES];
    logic signed [ACC_W-1:0] s1Prod_d [LANES];
    logic [ACC_W-1:0]        s1Bias_q;
    logic [4:0]              s1Shift_q;

    logic                    s2Valid_q, s2Last_q, s2Relu_q;
    logic signed [ACC_W-1:0] s2Sum_q, s2Sum_d;
    logic [ACC_W-1:0]        s2Bias_q;
    logic [4:0]              s2Shift_q;

    logic                    s3Valid_q, s3Last_q, s3Relu_q, first_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]              s3Shift_q;

    logic                    outValid_q, outSat_q, outSat_d;
    logic [N-1:0]            outDout_q, outDout_d;

    logic signed [ACC_W-1:0] roundedAcc, shifted;

    // A result sitting unconsumed in the output register freezes every stage.
    assign advance      = !outValid_q || accIf.out_rdy;
    assign accIf.in_rdy = advance;

    assign accIf.out_vld  = outValid_q;
    assign accIf.out_dout = outDout_q;
    assign accIf.out_sat  = outSat_q;
    assign accIf.busy     = !first_q || s1Valid_q || s2Valid_q || s3Valid_q || outValid_q;

    // S1 operands: per-lane products of the incoming beat.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1Prod_d[i] = laneProduct(accIf.input_din[i*N +: N], accIf.weight_din[i*N +: N]);
        end
    end

    // S2 operand: sum across all lanes of the registered products.
    always_comb begin
        s2Sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            s2Sum_d = s2Sum_d + s1Prod_q[i];
        end
    end

    // S3 operand: the first beat of a pixel restarts from its own bias.
    always_comb begin
        acc_d = (first_q ? $signed(s2Bias_q) : acc_q) + s2Sum_q;
    end

    // S4 operand: requantise the finished sum, then ReLU before saturation.
    always_comb begin
        roundedAcc = acc_q;
`ifdef PCONV_ROUND_EN
        if (s3Shift_q != 5'd0) begin
            roundedAcc = acc_q + (ACC_W'(1) << (s3Shift_q - 5'd1));
        end
`endif
        shifted   = roundedAcc >>> s3Shift_q;
        outDout_d = shifted[N-1:0];
        outSat_d  = 1'b0;
        if (s3Relu_q && shifted[ACC_W-1]) begin
            outDout_d = '0;
        end else if (shifted > POS_LIM) begin
            outDout_d = POS_LIM[N-1:0];
            outSat_d  = 1'b1;
        end else if (!s3Relu_q && shifted < NEG_LIM) begin
            outDout_d = NEG_LIM[N-1:0];
            outSat_d  = 1'b1;
        end
    end

    // Pipeline registers; sideband (bias, shift, relu, last) rides with its beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Last_q   <= 1'b0;
            s1Relu_q   <= 1'b0;
            s1Bias_q   <= '0;
            s1Shift_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1Prod_q[i] <= '0;
            end
            s2Valid_q  <= 1'b0;
            s2Last_q   <= 1'b0;
            s2Relu_q   <= 1'b0;
            s2Sum_q    <= '0;
            s2Bias_q   <= '0;
            s2Shift_q  <= '0;
            s3Valid_q  <= 1'b0;
            s3Last_q   <= 1'b0;
            s3Relu_q   <= 1'b0;
            s3Shift_q  <= '0;
            first_q    <= 1'b1;
            acc_q      <= '0;
            outValid_q <= 1'b0;
            outDout_q  <= '0;
            outSat_q   <= 1'b0;
        end else if (advance) begin
            s1Valid_q <= accIf.in_vld;
            s1Last_q  <= accIf.in_last;
            s1Relu_q  <= accIf.relu_en;
            s1Bias_q  <= accIf.bias_din;
            s1Shift_q <= accIf.shift_din;
            for (int i = 0; i < LANES; i++) begin
                s1Prod_q[i] <= s1Prod_d[i];
            end

            s2Valid_q <= s1Valid_q;
            s2Last_q  <= s1Last_q;
            s2Relu_q  <= s1Relu_q;
            s2Sum_q   <= s2Sum_d;
            s2Bias_q  <= s1Bias_q;
            s2Shift_q <= s1Shift_q;

            s3Valid_q <= s2Valid_q;
            if (s2Valid_q) begin
                acc_q     <= acc_d;
                first_q   <= s2Last_q;
                s3Last_q  <= s2Last_q;
                s3Relu_q  <= s2Relu_q;
                s3Shift_q <= s2Shift_q;
            end

            outValid_q <= s3Valid_q && s3Last_q;
            if (s3Valid_q && s3Last_q) begin
                outDout_q <= outDout_d;
                outSat_q  <= outSat_d;
            end
        end
    end
endmodule
